// File: rtl/fixed_to_float_pipe.sv
// Signed Q1.20 to IEEE-754 single converter, 3 enabled edges input to output, one sample per enabled cycle.
// No backpressure: clk_en freezes every stage and the consumer must take each out_valid pulse.
module fixed_to_float_pipe #(
  parameter int WIDTH = 21,
  parameter int FRAC  = 20
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] fixed_in,
  output logic             out_valid,
  output logic [31:0]      result
);

  localparam int PW = $clog2(WIDTH);

  logic             v1, s1;
  logic [WIDTH-1:0] m1;
  logic             v2, s2, z2;
  logic [PW-1:0]    p2;
  logic [22:0]      f2;

  logic [WIDTH-1:0] abs_in;
  logic [PW-1:0]    lod_p;
  logic [WIDTH-1:0] lod_rem;
  logic [22:0]      lod_frac;

  // -2^20 negates to itself, which read as unsigned is exactly 2^20.
  assign abs_in = fixed_in[WIDTH-1] ? (WIDTH'(0) - fixed_in) : fixed_in;

  always_comb begin
    lod_p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m1[i]) lod_p = PW'(i);
    end
    lod_rem  = m1 & ~(WIDTH'(1) << lod_p);
    lod_frac = 23'(lod_rem) << (23 - int'(lod_p));
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      v1        <= 1'b0;
      s1        <= 1'b0;
      m1        <= '0;
      v2        <= 1'b0;
      s2        <= 1'b0;
      z2        <= 1'b1;
      p2        <= '0;
      f2        <= '0;
      out_valid <= 1'b0;
      result    <= 32'h0;
    end else if (clk_en) begin
      v1 <= in_valid;
      s1 <= fixed_in[WIDTH-1];
      m1 <= abs_in;

      v2 <= v1;
      s2 <= s1;
      z2 <= (m1 == '0);
      p2 <= lod_p;
      f2 <= lod_frac;

      out_valid <= v2;
      if (v2) begin
        // Zero forces +0.0 regardless of the sampled sign bit.
        result <= {s2 & ~z2,
                   z2 ? 8'd0 : 8'(127 - FRAC) + 8'(p2),
                   z2 ? 23'd0 : f2};
      end
    end
  end

endmodule
